// File: rtl/pe_stripes_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial Stripes PE.
// Imported by the interface, the lane adder tree and the PE top.
package stripes_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_e;

    function automatic int out_width(input int n, input int w, input int pmax);
        return w + $clog2(n) + pmax;
    endfunction

    // Zero precision behaves as one slice; anything past PMAX saturates.
    function automatic int prec_clamp(input int p, input int pmax);
        if (p < 1) return 1;
        if (p > pmax) return pmax;
        return p;
    endfunction

endpackage

// File: rtl/pe_stripes_serial_if.sv
// Slice-in / result-out handshake bundle of the Stripes PE.
// slave = the PE, master = the slice streamer / result collector side.
interface pe_stripes_serial_if #(
    parameter int N    = 4,
    parameter int W    = 16,
    parameter int PMAX = 16
);
    import stripes_pkg::*;

    localparam int OW = out_width(N, W, PMAX);
    localparam int PW = $clog2(PMAX + 1);

    logic          i_valid;
    logic          o_ready;
    logic [N-1:0]  i_vec_a_bits;
    logic [N*W-1:0] i_vec_b;
    logic [OW-1:0] i_initial_sum;
    logic [PW-1:0] i_cfg_prec;
    logic          i_cfg_signed;
    logic          i_flush;
    logic          o_valid;
    logic          i_ready;
    logic [OW-1:0] o_dot_product;

    modport slave (
        input  i_valid, i_vec_a_bits, i_vec_b, i_initial_sum,
        input  i_cfg_prec, i_cfg_signed, i_flush, i_ready,
        output o_ready, o_valid, o_dot_product
    );

    modport master (
        output i_valid, i_vec_a_bits, i_vec_b, i_initial_sum,
        output i_cfg_prec, i_cfg_signed, i_flush, i_ready,
        input  o_ready, o_valid, o_dot_product
    );

endinterface

// File: rtl/pe_stripes_serial_tree.sv
// Combinational sum of the weight lanes whose activation bit is set,
// each lane sign-extended to WIDTH bits before adding.
module pe_lane_adder_tree #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int WIDTH = 34
) (
    input  logic [N-1:0]     i_mask,
    input  logic [N*W-1:0]   i_lanes,
    output logic [WIDTH-1:0] o_sum
);

    always_comb begin
        o_sum = '0;
        for (int i = 0; i < N; i++) begin
            if (i_mask[i]) begin
                o_sum = o_sum + WIDTH'($signed(i_lanes[i*W +: W]));
            end
        end
    end

endmodule

// File: rtl/pe_stripes_serial.sv
// Bit-serial Stripes PE: MSB-first activation slices against latched
// weights, one dot product per operation, valid/ready on both sides.
module pe_stripes_serial
    import stripes_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 16,
    parameter int PMAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    pe_stripes_serial_if.slave bus
);

    localparam int OW = out_width(N, W, PMAX);
    localparam int PW = $clog2(PMAX + 1);

    state_e         state_q, state_d;
    logic [PW-1:0]  k_q, k_d;
    logic [PW-1:0]  prec_q, prec_d;
    logic           sgn_q, sgn_d;
    logic [N*W-1:0] b_q, b_d;
    logic [OW-1:0]  init_q, init_d;
    logic [OW-1:0]  acc_q, acc_d;
    logic [OW-1:0]  dot_q, dot_d;

    logic           first;
    logic           fire;
    logic           last;
    logic           sgn_cur;
    logic [PW-1:0]  prec_cur;
    logic [N*W-1:0] b_cur;
    logic [OW-1:0]  init_cur;
    logic [OW-1:0]  tree_sum;
    logic [OW-1:0]  pp;
    logic [OW-1:0]  acc_nx;

    // The first slice uses the live operands; later slices the latched copy.
    assign first    = (state_q == S_IDLE);
    assign fire     = bus.i_valid && bus.o_ready;
    assign b_cur    = first ? bus.i_vec_b : b_q;
    assign init_cur = first ? bus.i_initial_sum : init_q;
    assign sgn_cur  = first ? bus.i_cfg_signed : sgn_q;
    assign prec_cur = first ? PW'(prec_clamp(int'(bus.i_cfg_prec), PMAX))
                            : prec_q;
    assign last     = (k_q == prec_cur - PW'(1));

    pe_lane_adder_tree #(
        .N     (N),
        .W     (W),
        .WIDTH (OW)
    ) u_tree (
        .i_mask  (bus.i_vec_a_bits),
        .i_lanes (b_cur),
        .o_sum   (tree_sum)
    );

    // Signed mode: the MSB slice carries weight -2^(prec-1).
    assign pp     = (sgn_cur && first) ? -tree_sum : tree_sum;
    assign acc_nx = first ? pp : (acc_q << 1) + pp;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        prec_d  = prec_q;
        sgn_d   = sgn_q;
        b_d     = b_q;
        init_d  = init_q;
        acc_d   = acc_q;
        dot_d   = dot_q;
        if (bus.i_flush) begin
            state_d = S_IDLE;
            k_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (fire) begin
                        if (first) begin
                            b_d    = bus.i_vec_b;
                            init_d = bus.i_initial_sum;
                            prec_d = prec_cur;
                            sgn_d  = bus.i_cfg_signed;
                        end
                        acc_d = acc_nx;
                        if (last) begin
                            dot_d   = acc_nx + init_cur;
                            k_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            k_d     = k_q + PW'(1);
                            state_d = S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.i_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            prec_q  <= '0;
            sgn_q   <= 1'b0;
            b_q     <= '0;
            init_q  <= '0;
            acc_q   <= '0;
            dot_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            prec_q  <= prec_d;
            sgn_q   <= sgn_d;
            b_q     <= b_d;
            init_q  <= init_d;
            acc_q   <= acc_d;
            dot_q   <= dot_d;
        end
    end

    assign bus.o_ready       = (state_q != S_DONE);
    assign bus.o_valid       = (state_q == S_DONE);
    assign bus.o_dot_product = dot_q;

endmodule

// File: tb/tb_pe_stripes_serial.sv
// Self-checking bench for pe_stripes_serial: directed cases plus random
// operations checked against a whole-operation dot-product model.
module tb_pe_stripes_serial;
    import stripes_pkg::*;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int PMAX = 16;
    localparam int OW   = out_width(N, W, PMAX);
    localparam int PW   = $clog2(PMAX + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pe_stripes_serial_if #(.N(N), .W(W), .PMAX(PMAX)) bus ();

    pe_stripes_serial #(.N(N), .W(W), .PMAX(PMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [OW-1:0] exp_q[$];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Dot product from whole activation values, no slicing involved.
    function automatic logic [OW-1:0] model(input logic [3:0][15:0] aa,
                                             input logic [3:0][15:0] bb,
                                             input logic [OW-1:0] init,
                                             input int prec, input bit sgn);
        int p;
        longint s;
        longint v;
        longint mask;
        p = (prec < 1) ? 1 : ((prec > PMAX) ? PMAX : prec);
        mask = (longint'(1) << p) - 1;
        s = longint'(init);
        for (int i = 0; i < N; i++) begin
            v = longint'(aa[i]) & mask;
            if (sgn && v[p-1]) v = v - (longint'(1) << p);
            s = s + v * longint'($signed(bb[i]));
        end
        return OW'(s);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(bus.o_valid), 64'(0));
                end else begin
                    check("dot_product", 64'(bus.o_dot_product), 64'(exp_q[0]));
                    check("ready_low_in_done", 64'(bus.o_ready), 64'(0));
                    if (bus.i_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive_slice(input logic [3:0] bits, input logic [63:0] b,
                               input logic [OW-1:0] init,
                               input logic [PW-1:0] prec,
                               input logic sgn, input logic fl);
        check("ready_for_slice", 64'(bus.o_ready), 64'(1));
        bus.i_valid       = 1'b1;
        bus.i_vec_a_bits  = bits;
        bus.i_vec_b       = b;
        bus.i_initial_sum = init;
        bus.i_cfg_prec    = prec;
        bus.i_cfg_signed  = sgn;
        bus.i_flush       = fl;
        @(negedge clk);
        bus.i_valid      = 1'b0;
        bus.i_flush      = 1'b0;
        bus.i_vec_a_bits = 4'($urandom);
        bus.i_vec_b      = {$urandom, $urandom};
    endtask

    // abort_at: slice index where a reset (kind 0) or flush (kind 1) hits.
    // rmode: 0 = i_ready high, 1 = random stalls, 2 = 3-cycle backpressure.
    task automatic run_op(input logic [3:0][15:0] aa,
                          input logic [3:0][15:0] bb,
                          input logic [OW-1:0] init, input int prec,
                          input bit sgn, input int gap,
                          input logic [OW-1:0] exp,
                          input int abort_at, input int kind,
                          input int rmode);
        int p;
        int t;
        logic [3:0] bits;
        p = (prec < 1) ? 1 : ((prec > PMAX) ? PMAX : prec);
        for (int k = 0; k < p; k++) begin
            for (int i = 0; i < N; i++) bits[i] = aa[i][p-1-k];
            if (k == abort_at && kind == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #1;
                check("rst_valid", 64'(bus.o_valid), 64'(0));
                check("rst_ready", 64'(bus.o_ready), 64'(1));
                check("rst_dot", 64'(bus.o_dot_product), 64'(0));
                rst_n = 1'b1;
                return;
            end
            if (k == abort_at) begin
                drive_slice(bits, 64'(bb), OW'({$urandom, $urandom}),
                            PW'($urandom), 1'($urandom), 1'b1);
                #1;
                check("flush_valid", 64'(bus.o_valid), 64'(0));
                check("flush_ready", 64'(bus.o_ready), 64'(1));
                return;
            end
            if (k == p - 1) exp_q.push_back(exp);
            if (k == 0)
                drive_slice(bits, 64'(bb), init, PW'(prec), sgn, 1'b0);
            else
                drive_slice(bits, {$urandom, $urandom},
                            OW'({$urandom, $urandom}), PW'($urandom),
                            1'($urandom), 1'b0);
            if (k == p - 1) begin
                if (rmode == 1) bus.i_ready = 1'($urandom);
                if (rmode == 2) bus.i_ready = 1'b0;
                #1;
                check("valid_after_last", 64'(bus.o_valid), 64'(1));
            end else begin
                for (int g = 0; g < gap; g++) begin
                    check("ready_in_gap", 64'(bus.o_ready), 64'(1));
                    @(negedge clk);
                end
            end
        end
        if (rmode == 2) begin
            bus.i_valid      = 1'b1;
            bus.i_vec_a_bits = 4'hF;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                #1;
                check("bp_valid_held", 64'(bus.o_valid), 64'(1));
                check("bp_ready_low", 64'(bus.o_ready), 64'(0));
            end
            bus.i_valid = 1'b0;
            bus.i_ready = 1'b1;
        end
        t = 0;
        while (t < 60) begin
            @(negedge clk);
            if (!bus.o_valid) break;
            bus.i_ready = (rmode == 1) ? 1'($urandom) : 1'b1;
            t++;
        end
        bus.i_ready = 1'b1;
        check("result_drained", 64'(bus.o_valid), 64'(0));
    endtask

    logic [3:0][15:0] t1a, t1b, t2a, t2b, t3a, t3b, t5a, t5b, ra, rb;
    logic [OW-1:0]    rinit;
    int               rprec;
    bit               rsgn;

    initial begin
        t1a = {16'd15, 16'd0, 16'd3, 16'd5};
        t1b = {16'd4, 16'd3, 16'd2, 16'd1};
        t2a = {16'h8, 16'h0, 16'h2, 16'hF};
        t2b = {16'd1, 16'd7, 16'd5, 16'd3};
        t3a = {16'd0, 16'd0, 16'd0, 16'd1};
        t3b = {16'd0, 16'd0, 16'd0, 16'd7};
        t5a = {16'd2, 16'd0, 16'd1, 16'd3};
        t5b = {16'd2, 16'd2, 16'd2, 16'd2};

        bus.i_valid       = 1'b0;
        bus.i_ready       = 1'b1;
        bus.i_flush       = 1'b0;
        bus.i_vec_a_bits  = '0;
        bus.i_vec_b       = '0;
        bus.i_initial_sum = '0;
        bus.i_cfg_prec    = '0;
        bus.i_cfg_signed  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", 64'(bus.o_valid), 64'(0));
        check("reset_ready", 64'(bus.o_ready), 64'(1));
        check("reset_dot", 64'(bus.o_dot_product), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        check("model_pin_t1", 64'(model(t1a, t1b, '0, 4, 1'b0)), 64'(71));
        check("model_pin_t2", 64'(model(t2a, t2b, 34'd10, 4, 1'b1)), 64'(9));

        run_op(t1a, t1b, '0, 4, 1'b0, 0, 34'd71, -1, 0, 0);
        run_op(t2a, t2b, 34'd10, 4, 1'b1, 0, 34'd9, -1, 0, 0);
        run_op(t3a, t3b, '0, 1, 1'b1, 0, -34'sd7, -1, 0, 0);
        run_op(t3a, t3b, '0, 1, 1'b0, 0, 34'd7, -1, 0, 0);
        run_op(t1a, t1b, '0, 4, 1'b0, 2, 34'd71, -1, 0, 0);
        run_op(t1a, t1b, '0, 4, 1'b0, 0, 34'd71, -1, 0, 2);
        run_op(t5a, t5b, '0, 2, 1'b0, 0, 34'd12, -1, 0, 0);
        run_op(t1a, t1b, '0, 4, 1'b0, 0, 34'd71, 2, 0, 0);
        run_op(t1a, t1b, '0, 4, 1'b0, 0, 34'd71, -1, 0, 0);
        run_op(t1a, t1b, '0, 4, 1'b0, 0, 34'd71, 2, 1, 0);
        run_op(t1a, t1b, '0, 4, 1'b0, 0, 34'd71, -1, 0, 0);
        run_op(t3a, t3b, '0, 0, 1'b0, 0, 34'd7, -1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            ra    = {$urandom, $urandom};
            rb    = {$urandom, $urandom};
            rinit = OW'({$urandom, $urandom});
            rprec = $urandom_range(0, 20);
            rsgn  = 1'($urandom);
            run_op(ra, rb, rinit, rprec, rsgn, $urandom_range(0, 2),
                   model(ra, rb, rinit, rprec, rsgn), -1, 0, 1);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
